// File: rtl/aes_key_schedule_if.sv
// Bus between the AES-128 key schedule and its encryptor. The master side drives the
// key load and read address, and the slave side returns the round keys and status.
interface aes_key_schedule_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              key_load;
  logic [127:0]      cipher_key;
  logic [ADDR_W-1:0] round_key_addr;
  logic [127:0]      round_key_0;
  logic [127:0]      round_key_input;
  logic              key_busy;
  logic              keys_ready;

  modport master (
    output key_load,
    output cipher_key,
    output round_key_addr,
    input  round_key_0,
    input  round_key_input,
    input  key_busy,
    input  keys_ready
  );

  modport slave (
    input  key_load,
    input  cipher_key,
    input  round_key_addr,
    output round_key_0,
    output round_key_input,
    output key_busy,
    output keys_ready
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion. It produces one 32-bit word per clock and stores round keys
// 1..10 in a register file. Reads are registered and take one cycle.
module aes_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              tb_clk,
  input  logic              tb_n_rst,
  aes_key_schedule_if.slave bus
);

  localparam logic [2047:0] SboxTbl = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  // Entry 0 sits in the top byte, so the slice offset is (255 - x) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SboxTbl[idx +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e            state_q;
  logic [31:0]       win_q [4];  // w[i-4] .. w[i-1]
  logic [5:0]        cnt_q;
  logic [7:0]        rcon_q;
  logic [127:0]      key_reg_q [NUM_ROUNDS];
  logic [127:0]      rk0_q;
  logic [127:0]      rd_q;
  logic              busy_q;
  logic              ready_q;

  logic [31:0]       rot_word;
  logic [31:0]       sub_word;
  logic [31:0]       temp_word;
  logic [31:0]       new_word;
  logic [7:0]        rcon_nxt;
  logic [3:0]        widx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;

  always_comb begin
    rot_word  = {win_q[3][23:0], win_q[3][31:24]};
    sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                 sbox(rot_word[15:8]), sbox(rot_word[7:0])};
    temp_word = (cnt_q[1:0] == 2'd0) ? (sub_word ^ {rcon_q, 24'h0}) : win_q[3];
    new_word  = win_q[0] ^ temp_word;
    rcon_nxt  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    widx      = cnt_q[5:2] - 4'd1;
    rd_addr   = bus.round_key_addr;
    // A load edge hides the old keys at once, including the read taken on that edge.
    rd_ok     = ready_q && !bus.key_load && (32'(rd_addr) < NUM_ROUNDS);
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state_q <= StIdle;
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
      for (int i = 0; i < int'(NUM_ROUNDS); i++) key_reg_q[i] <= '0;
      cnt_q   <= 6'd4;
      rcon_q  <= 8'h01;
      rk0_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      rd_q <= rd_ok ? key_reg_q[rd_addr] : '0;
      if (bus.key_load) begin
        rk0_q    <= bus.cipher_key;
        win_q[0] <= bus.cipher_key[127:96];
        win_q[1] <= bus.cipher_key[95:64];
        win_q[2] <= bus.cipher_key[63:32];
        win_q[3] <= bus.cipher_key[31:0];
        cnt_q    <= 6'd4;
        rcon_q   <= 8'h01;
        ready_q  <= 1'b0;
        busy_q   <= 1'b1;
        state_q  <= StExpand;
      end else if (state_q == StExpand) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= win_q[3];
        win_q[3] <= new_word;
        cnt_q    <= cnt_q + 6'd1;
        if (cnt_q[1:0] == 2'd0) rcon_q <= rcon_nxt;
        if (cnt_q[1:0] == 2'd3) key_reg_q[widx] <= {win_q[1], win_q[2], win_q[3], new_word};
        if (cnt_q == 6'd43) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StDone;
        end
      end
    end
  end

  assign bus.round_key_0     = rk0_q;
  assign bus.round_key_input = rd_q;
  assign bus.key_busy        = busy_q;
  assign bus.keys_ready      = ready_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule. It uses the FIPS-197 A.1 and C.1 keys, an
// address sweep, restart, reload and asynchronous reset sequences.
module tb_aes_key_schedule;

  logic tb_clk = 1'b0;
  logic tb_n_rst;

  aes_key_schedule_if #(.ADDR_W(4)) bus ();

  aes_key_schedule #(
    .NUM_ROUNDS(10),
    .ADDR_W    (4)
  ) dut (
    .tb_clk  (tb_clk),
    .tb_n_rst(tb_n_rst),
    .bus     (bus)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] KeyA1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KeyC1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rk0"},   bus.round_key_0, '0);
    chk({tag, "_rd"},    bus.round_key_input, '0);
    chk({tag, "_busy"},  128'(bus.key_busy), '0);
    chk({tag, "_ready"}, 128'(bus.keys_ready), '0);
  endtask

  // Called just after a negedge. The load edge is the next posedge.
  task automatic do_load(input logic [127:0] key);
    bus.cipher_key = key;
    bus.key_load   = 1'b1;
    @(negedge tb_clk);
    bus.key_load = 1'b0;
    chk("round_key_0_after_load", bus.round_key_0, key);
    chk("busy_after_load", 128'(bus.key_busy), 128'd1);
    chk("ready_after_load", 128'(bus.keys_ready), 128'd0);
  endtask

  // Counts the edges from the load edge until keys_ready is seen. The loop is bounded.
  task automatic wait_ready(input int exp_lat);
    int n;
    n = 0;
    while (bus.keys_ready !== 1'b1 && n < 100) begin
      chk("read_zero_while_expanding", bus.round_key_input, '0);
      chk("busy_while_expanding", 128'(bus.key_busy), 128'd1);
      @(negedge tb_clk);
      n++;
    end
    chk("latency", 128'(n), 128'(exp_lat));
    chk("busy_at_ready", 128'(bus.key_busy), 128'd0);
    chk("read_zero_at_ready_edge", bus.round_key_input, '0);
  endtask

  // Drives a new address every cycle and checks each result one cycle later.
  task automatic sweep(input string tag);
    for (int j = 0; j < 16; j++) begin
      bus.round_key_addr = vecs[j].addr;
      @(negedge tb_clk);
      chk($sformatf("%s_addr%0d", tag, j), bus.round_key_input, vecs[j].exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd0, 128'ha0fafe17_88542cb1_23a33939_2a6c7605};
    vecs[1] = '{4'd1, 128'hf2c295f2_7a96b943_5935807a_7359f67f};
    vecs[2] = '{4'd2, 128'h3d80477d_4716fe3e_1e237e44_6d7a883b};
    vecs[3] = '{4'd3, 128'hef44a541_a8525b7f_b671253b_db0bad00};
    vecs[4] = '{4'd4, 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc};
    vecs[5] = '{4'd5, 128'h6d88a37a_110b3efd_dbf98641_ca0093fd};
    vecs[6] = '{4'd6, 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f};
    vecs[7] = '{4'd7, 128'head27321_b58dbad2_312bf560_7f8d292f};
    vecs[8] = '{4'd8, 128'hac7766f3_19fadc21_28d12941_575c006e};
    vecs[9] = '{4'd9, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    for (int j = 10; j < 16; j++) vecs[j] = '{4'(j), 128'h0};

    tb_n_rst           = 1'b0;
    bus.key_load       = 1'b0;
    bus.cipher_key     = '0;
    bus.round_key_addr = '0;
    #3;
    chk_all_zero("reset");

    @(negedge tb_clk);
    tb_n_rst = 1'b1;
    repeat (3) @(negedge tb_clk);
    chk_all_zero("idle_no_load");

    // FIPS-197 A.1
    bus.round_key_addr = 4'd0;
    do_load(KeyA1);
    wait_ready(40);
    @(negedge tb_clk);
    chk("a1_addr0", bus.round_key_input, vecs[0].exp);
    bus.round_key_addr = 4'd9;
    @(negedge tb_clk);
    chk("a1_addr9", bus.round_key_input, vecs[9].exp);
    sweep("a1_sweep");

    // Reload while in DONE
    bus.round_key_addr = 4'd9;
    do_load(KeyC1);
    wait_ready(40);
    @(negedge tb_clk);
    chk("c1_addr9", bus.round_key_input, 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);
    bus.round_key_addr = 4'd0;
    @(negedge tb_clk);
    chk("c1_addr0", bus.round_key_input, 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe);

    // Restart mid-expansion: the second load falls on edge 17 after the first load
    do_load(KeyC1);
    repeat (16) begin
      chk("restart_ready_low", 128'(bus.keys_ready), 128'd0);
      @(negedge tb_clk);
    end
    do_load(KeyA1);
    wait_ready(40);
    sweep("restart_sweep");

    // Asynchronous reset partway through an expansion
    do_load(KeyA1);
    repeat (19) @(negedge tb_clk);
    #2 tb_n_rst = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge tb_clk);
    tb_n_rst           = 1'b1;
    bus.round_key_addr = 4'd9;
    repeat (50) begin
      @(negedge tb_clk);
      chk("post_reset_ready", 128'(bus.keys_ready), 128'd0);
      chk("post_reset_busy", 128'(bus.key_busy), 128'd0);
      chk("post_reset_rd", bus.round_key_input, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
